ball_control: RTL and testbench

BALL_CONTROL -- requirements
Module: ball_control

---
 rtl/ball_control.sv | 185 ++++++++++++++++++
 tb/tb_ball_control.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ball_control.sv
// Ball motion, paddle/wall reflection, miss scoring and display-scan row
// generation for a two-player paddle game on a WIDTH x WIDTH playfield.
module ball_control #(
    parameter int WIDTH        = 8,
    parameter int BIT_OF_WIDTH = 3,
    parameter int STEP_CYCLES  = 8,
    parameter int WIN_SCORE    = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [7:0]              hit_info,
    output logic [BIT_OF_WIDTH-1:0] x_pos,
    output logic [BIT_OF_WIDTH-1:0] y_pos,
    output logic [2:0]              count,
    output logic [WIDTH-1:0]        ball_row,
    output logic                    miss_top,
    output logic                    miss_down,
    output logic [3:0]              score_top,
    output logic [3:0]              score_down,
    output logic                    game_over
);

    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [SW-1:0]           STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [BIT_OF_WIDTH-1:0] CENTER    = BIT_OF_WIDTH'(WIDTH / 2 - 1);
    localparam logic [BIT_OF_WIDTH-1:0] X_MAX     = BIT_OF_WIDTH'(WIDTH - 1);
    localparam logic [BIT_OF_WIDTH-1:0] ROW_TOP   = '0;
    localparam logic [BIT_OF_WIDTH-1:0] ROW_TOP_HIT = BIT_OF_WIDTH'(1);
    localparam logic [BIT_OF_WIDTH-1:0] ROW_BOT_HIT = BIT_OF_WIDTH'(WIDTH - 2);
    localparam logic [BIT_OF_WIDTH-1:0] ROW_BOT   = BIT_OF_WIDTH'(WIDTH - 1);
    localparam logic [3:0]              WIN       = 4'(WIN_SCORE);

    typedef enum logic [1:0] {IDLE, MOVE, MISS, OVER} state_t;

    state_t                  state, state_nxt;
    logic [SW-1:0]           step_cnt, step_nxt;
    logic [BIT_OF_WIDTH-1:0] x_nxt, y_nxt;
    logic                    dx_neg, dx_nxt;   // 1: moving towards column 0
    logic                    dy_neg, dy_nxt;   // 1: moving towards the top paddle
    logic                    miss_top_nxt, miss_down_nxt;
    logic [3:0]              score_top_nxt, score_down_nxt;
    logic                    tick_due;
    logic                    dx_wall, dx_new;
    logic                    top_hit, top_angled, bot_hit, bot_angled;
    logic                    unused_hit;

    // Scores stop at 15 instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == 4'hF) ? s : s + 4'd1;
    endfunction

    assign tick_due = (step_cnt == STEP_LAST);

    // Wall bounce is resolved before paddle checks, so paddle angles use the bounced direction.
    assign dx_wall = ((x_pos == '0) && dx_neg)     ? 1'b0 :
                     ((x_pos == X_MAX) && !dx_neg) ? 1'b1 : dx_neg;

    // A straight hit (centre bit) takes priority over an angled one.
    assign top_angled = !hit_info[1] && (dx_wall ? hit_info[0] : hit_info[2]);
    assign top_hit    = hit_info[1] || top_angled;
    assign bot_angled = !hit_info[6] && (dx_wall ? hit_info[5] : hit_info[7]);
    assign bot_hit    = hit_info[6] || bot_angled;
    assign unused_hit = ^hit_info[4:3];

    assign game_over = (state == OVER);

    // State and ball registers; reset abandons any step or miss in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            step_cnt   <= '0;
            x_pos      <= CENTER;
            y_pos      <= CENTER;
            dx_neg     <= 1'b0;
            dy_neg     <= 1'b0;
            miss_top   <= 1'b0;
            miss_down  <= 1'b0;
            score_top  <= 4'd0;
            score_down <= 4'd0;
            count      <= 3'd0;
        end else begin
            state      <= state_nxt;
            step_cnt   <= step_nxt;
            x_pos      <= x_nxt;
            y_pos      <= y_nxt;
            dx_neg     <= dx_nxt;
            dy_neg     <= dy_nxt;
            miss_top   <= miss_top_nxt;
            miss_down  <= miss_down_nxt;
            score_top  <= score_top_nxt;
            score_down <= score_down_nxt;
            count      <= count + 3'd1;
        end
    end

    // Next-state logic: serve, per-tick ball step, miss hold/recentre, game-over clear.
    always_comb begin
        state_nxt      = state;
        step_nxt       = step_cnt;
        x_nxt          = x_pos;
        y_nxt          = y_pos;
        dx_nxt         = dx_neg;
        dy_nxt         = dy_neg;
        miss_top_nxt   = 1'b0;
        miss_down_nxt  = 1'b0;
        score_top_nxt  = score_top;
        score_down_nxt = score_down;
        dx_new         = dx_wall;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = MOVE;
                    step_nxt  = '0;
                end
            end
            MOVE: begin
                if (!tick_due) begin
                    step_nxt = step_cnt + 1'b1;
                end else begin
                    step_nxt = '0;
                    if ((y_pos == ROW_TOP_HIT) && dy_neg) begin
                        if (top_hit) begin
                            dy_nxt = 1'b0;
                            y_nxt  = ROW_TOP_HIT + 1'b1;
                            if (top_angled) dx_new = !dx_wall;
                        end else begin
                            y_nxt          = ROW_TOP;
                            miss_top_nxt   = 1'b1;
                            score_down_nxt = sat_inc(score_down);
                            state_nxt      = MISS;
                        end
                    end else if ((y_pos == ROW_BOT_HIT) && !dy_neg) begin
                        if (bot_hit) begin
                            dy_nxt = 1'b1;
                            y_nxt  = ROW_BOT_HIT - 1'b1;
                            if (bot_angled) dx_new = !dx_wall;
                        end else begin
                            y_nxt         = ROW_BOT;
                            miss_down_nxt = 1'b1;
                            score_top_nxt = sat_inc(score_top);
                            state_nxt     = MISS;
                        end
                    end else begin
                        y_nxt = dy_neg ? y_pos - 1'b1 : y_pos + 1'b1;
                    end
                    dx_nxt = dx_new;
                    x_nxt  = dx_new ? x_pos - 1'b1 : x_pos + 1'b1;
                end
            end
            MISS: begin
                if (!tick_due) begin
                    step_nxt = step_cnt + 1'b1;
                end else begin
                    // dy still points at the player who missed, so the serve goes back to them.
                    step_nxt  = '0;
                    x_nxt     = CENTER;
                    y_nxt     = CENTER;
                    dx_nxt    = 1'b0;
                    state_nxt = ((score_top == WIN) || (score_down == WIN)) ? OVER : IDLE;
                end
            end
            OVER: begin
                if (start) begin
                    score_top_nxt  = 4'd0;
                    score_down_nxt = 4'd0;
                    x_nxt          = CENTER;
                    y_nxt          = CENTER;
                    dx_nxt         = 1'b0;
                    dy_nxt         = 1'b0;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Scan-row pattern: the ball's column lights only on the row being scanned.
    always_comb begin
        ball_row = '0;
        if (count == y_pos) ball_row[x_pos] = 1'b1;
    end

endmodule

// File: tb/tb_ball_control.sv
// Directed scoreboard bench for ball_control (STEP_CYCLES=4, WIN_SCORE=2).
module tb_ball_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] hit_info;
    logic [2:0] x_pos, y_pos, count;
    logic [7:0] ball_row;
    logic       miss_top, miss_down, game_over;
    logic [3:0] score_top, score_down;

    ball_control #(.WIDTH(8), .BIT_OF_WIDTH(3), .STEP_CYCLES(4), .WIN_SCORE(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hit_info(hit_info),
        .x_pos(x_pos), .y_pos(y_pos), .count(count), .ball_row(ball_row),
        .miss_top(miss_top), .miss_down(miss_down),
        .score_top(score_top), .score_down(score_down), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
        logic       mt;
        logic       md;
        logic [3:0] st;
        logic [3:0] sd;
        logic       go;
    } rec_t;

    rec_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   armed = 0;
    logic [2:0] m_cnt;

    // Reference scan counter.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) m_cnt <= 3'd0;
        else        m_cnt <= m_cnt + 3'd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [2:0] x, input logic [2:0] y, input logic mt, input logic md,
                        input logic [3:0] st, input logic [3:0] sd, input logic go);
        rec_t r;
        r.x = x; r.y = y; r.mt = mt; r.md = md; r.st = st; r.sd = sd; r.go = go;
        exp_q.push_back(r);
    endtask

    // One step period: junk on non-tick cycles, the real hit_info on the tick edge.
    task automatic tick(input logic [7:0] h, input logic [2:0] x, input logic [2:0] y,
                        input logic mt, input logic md, input logic [3:0] st,
                        input logic [3:0] sd, input logic go);
        push(x, y, mt, md, st, sd, go);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start    = (i < 4);
            hit_info = (i < 4) ? 8'hFF : h;
        end
    endtask

    task automatic serve();
        @(negedge clk);
        start    = 1'b1;
        hit_info = 8'hFF;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start    = 1'b0;
            hit_info = 8'hFF;
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_x"}, x_pos, 3);
        chk({tag, "_y"}, y_pos, 3);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_miss_top"}, miss_top, 0);
        chk({tag, "_miss_down"}, miss_down, 0);
        chk({tag, "_score_top"}, score_top, 0);
        chk({tag, "_score_down"}, score_down, 0);
        chk({tag, "_game_over"}, game_over, 0);
        chk({tag, "_ball_row"}, ball_row, 0);
    endtask

    // Monitor: any visible change of ball/score/game_over is a transaction to score.
    initial begin
        rec_t prev, cur, e;
        prev = '0;
        forever begin
            @(posedge clk);
            #2;
            cur.x = x_pos; cur.y = y_pos; cur.mt = miss_top; cur.md = miss_down;
            cur.st = score_top; cur.sd = score_down; cur.go = game_over;
            if (armed) begin
                chk("count", count, m_cnt);
                if ({cur.x, cur.y, cur.st, cur.sd, cur.go} != {prev.x, prev.y, prev.st, prev.sd, prev.go}) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_event: got x=%0d y=%0d st=%0d sd=%0d go=%0d expected no change",
                                 cur.x, cur.y, cur.st, cur.sd, cur.go);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ev_x", cur.x, e.x);
                        chk("ev_y", cur.y, e.y);
                        chk("ev_miss_top", cur.mt, e.mt);
                        chk("ev_miss_down", cur.md, e.md);
                        chk("ev_score_top", cur.st, e.st);
                        chk("ev_score_down", cur.sd, e.sd);
                        chk("ev_game_over", cur.go, e.go);
                    end
                end else begin
                    chk("miss_quiet", {cur.mt, cur.md}, 0);
                end
            end
            prev = cur;
        end
    end

    initial begin
        rst_n    = 1'b1;
        start    = 1'b0;
        hit_info = 8'h00;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);
        armed = 1;

        // Scan with ball parked at (3,3).
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("scan_row", ball_row, (m_cnt == 3'd3) ? 8'h08 : 8'h00);
        end

        // Rally 1: diagonal serve, straight bottom hit, wall, angled top hit (bit0), wall, bottom miss.
        serve();
        tick(8'h00, 4, 4, 0, 0, 0, 0, 0);
        tick(8'h00, 5, 5, 0, 0, 0, 0, 0);
        tick(8'h00, 6, 6, 0, 0, 0, 0, 0);
        tick(8'h40, 7, 5, 0, 0, 0, 0, 0);
        tick(8'h00, 6, 4, 0, 0, 0, 0, 0);
        tick(8'h00, 5, 3, 0, 0, 0, 0, 0);
        tick(8'h00, 4, 2, 0, 0, 0, 0, 0);
        tick(8'h00, 3, 1, 0, 0, 0, 0, 0);
        tick(8'h01, 4, 2, 0, 0, 0, 0, 0);
        tick(8'h00, 5, 3, 0, 0, 0, 0, 0);
        tick(8'h00, 6, 4, 0, 0, 0, 0, 0);
        tick(8'h00, 7, 5, 0, 0, 0, 0, 0);
        tick(8'h00, 6, 6, 0, 0, 0, 0, 0);
        tick(8'h00, 5, 7, 0, 1, 1, 0, 0);
        tick(8'hFF, 3, 3, 0, 0, 1, 0, 0);

        // Rally 2: bottom hit, wall, top miss where only the trailing-side bit is set.
        serve();
        tick(8'h00, 4, 4, 0, 0, 1, 0, 0);
        tick(8'h00, 5, 5, 0, 0, 1, 0, 0);
        tick(8'h00, 6, 6, 0, 0, 1, 0, 0);
        tick(8'h40, 7, 5, 0, 0, 1, 0, 0);
        tick(8'h00, 6, 4, 0, 0, 1, 0, 0);
        tick(8'h00, 5, 3, 0, 0, 1, 0, 0);
        tick(8'h00, 4, 2, 0, 0, 1, 0, 0);
        tick(8'h00, 3, 1, 0, 0, 1, 0, 0);
        tick(8'h04, 2, 0, 1, 0, 1, 1, 0);
        tick(8'hFF, 3, 3, 0, 0, 1, 1, 0);

        // Rally 3: serve upward, top miss reaches WIN_SCORE, game over.
        serve();
        tick(8'h00, 4, 2, 0, 0, 1, 1, 0);
        tick(8'h00, 5, 1, 0, 0, 1, 1, 0);
        tick(8'h01, 6, 0, 1, 0, 1, 2, 0);
        tick(8'hFF, 3, 3, 0, 0, 1, 2, 1);
        idle(3);
        chk("over_hold", game_over, 1);

        // Clear from OVER; the same start must not serve.
        push(3, 3, 0, 0, 0, 0, 0);
        @(negedge clk);
        start = 1'b1;
        idle(6);
        chk("cleared_x", x_pos, 3);
        chk("cleared_y", y_pos, 3);

        // Serve after clear goes downward; then reset mid-step.
        serve();
        tick(8'h00, 4, 4, 0, 0, 0, 0, 0);
        idle(2);
        push(3, 3, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk_reset_state("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(10);
        chk("post_reset_row", ball_row, (m_cnt == 3'd3) ? 8'h08 : 8'h00);

        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
